// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and types for the SPI byte slave
package spi_pkg;

  // SCLK idle level (CPOL) and sampling edge (CPHA) encodings
  localparam logic CPOL_IDLE_LOW    = 1'b0;
  localparam logic CPOL_IDLE_HIGH   = 1'b1;
  localparam logic CPHA_FIRST_EDGE  = 1'b0;
  localparam logic CPHA_SECOND_EDGE = 1'b1;

  // Byte driven on MISO when the controller has nothing queued
  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

  // Bit position within the current byte
  localparam int BIT_CNT_W = 3;

  // DISARMED: cs_n has not been seen high since reset, so any frame in
  // progress is ignored. ARMED: idle, waiting for cs_n to fall.
  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FRAME    = 2'd2
  } frame_state_t;

  // Data is sampled on the rising SCLK edge when CPOL and CPHA agree
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_byte_slave_pin_synchronizer.sv
// rtl/spi_byte_slave_pin_synchronizer.sv - multi-flop synchroniser for one asynchronous pin
module pin_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  // Shift the pin through the flop chain; the last stage is the safe copy
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/spi_byte_slave.sv
// rtl/spi_byte_slave.sv - oversampled SPI slave: MOSI byte strobes, MISO serialiser, frame events
module spi_byte_slave
  import spi_pkg::*;
#(
  parameter logic       CPOL        = CPOL_IDLE_LOW,
  parameter logic       CPHA        = CPHA_FIRST_EDGE,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        cs_n_out,
  output logic [7:0]  data_out,
  output logic        data_out_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        frame_start,
  output logic        frame_end,
  output logic        frame_abort,
  output logic [15:0] byte_count,
  output logic        tx_underrun
);

  localparam logic SAMPLE_ON_RISE = sample_on_rise(CPOL, CPHA);

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_cs_s;
  logic r_sclk_d;
  logic r_cs_d;

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_sample_edge;
  logic w_launch_edge;
  logic w_cs_rise;
  logic w_cs_fall;

  frame_state_t r_state;
  frame_state_t w_state_next;
  logic         w_frame_begin;
  logic         w_frame_close;
  logic         w_sample;
  logic         w_launch;
  logic         w_load;
  logic         w_shift;

  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [7:0]           r_rx_shift;
  logic [7:0]           r_tx_shift;
  logic [7:0]           r_data_out;
  logic                 r_data_out_ready;
  logic                 r_frame_start;
  logic                 r_frame_end;
  logic                 r_frame_abort;
  logic [15:0]          r_byte_count;
  logic                 r_tx_underrun;

  // SCLK resets to its idle level so no edge is seen on reset release.
  // cs_n resets to "asserted" so a frame already running across reset
  // cannot look like a fresh cs_n fall.
  pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_async (spi_sclk),
    .o_sync  (w_sclk_s)
  );

  pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_async (spi_mosi),
    .o_sync  (w_mosi_s)
  );

  pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_async (spi_cs_n),
    .o_sync  (w_cs_s)
  );

  // One further delayed copy of SCLK and cs_n for edge detection
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_sclk_d <= CPOL;
      r_cs_d   <= 1'b0;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_cs_d   <= w_cs_s;
    end
  end

  assign w_sclk_rise   = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall   = ~w_sclk_s & r_sclk_d;
  assign w_sample_edge = SAMPLE_ON_RISE ? w_sclk_rise : w_sclk_fall;
  assign w_launch_edge = SAMPLE_ON_RISE ? w_sclk_fall : w_sclk_rise;
  assign w_cs_rise     = w_cs_s & ~r_cs_d;
  assign w_cs_fall     = ~w_cs_s & r_cs_d;

  // Frame state register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= ST_DISARMED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Arming, frame entry/exit and qualification of SCLK edges; a cs_n rise
  // takes priority over an SCLK edge detected in the same cycle
  always_comb begin
    w_state_next  = r_state;
    w_frame_begin = 1'b0;
    w_frame_close = 1'b0;
    w_sample      = 1'b0;
    w_launch      = 1'b0;
    case (r_state)
      ST_DISARMED: begin
        if (w_cs_s) begin
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_cs_fall) begin
          w_state_next  = ST_FRAME;
          w_frame_begin = 1'b1;
        end
      end
      ST_FRAME: begin
        if (w_cs_rise) begin
          w_state_next  = ST_ARMED;
          w_frame_close = 1'b1;
        end else begin
          w_sample = w_sample_edge;
          w_launch = w_launch_edge;
        end
      end
      default: begin
        w_state_next = ST_DISARMED;
      end
    endcase
  end

  // With CPHA=0 the first bit must be on MISO before the first SCLK edge,
  // so loads happen at frame start and on the last sample of each byte.
  // With CPHA=1 the byte is loaded on its own first launch edge. In both
  // modes the launch edge at bit 0 is the load slot and must not shift.
  assign w_load  = (CPHA == CPHA_FIRST_EDGE)
                 ? (w_frame_begin | (w_sample & (r_bit_cnt == '1)))
                 : (w_launch & (r_bit_cnt == '0));
  assign w_shift = w_launch & (r_bit_cnt != '0);

  // Receive shifter, byte strobes, frame pulses and transmit shifter
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_bit_cnt        <= '0;
      r_rx_shift       <= '0;
      r_tx_shift       <= '0;
      r_data_out       <= '0;
      r_data_out_ready <= 1'b0;
      r_frame_start    <= 1'b0;
      r_frame_end      <= 1'b0;
      r_frame_abort    <= 1'b0;
      r_byte_count     <= '0;
      r_tx_underrun    <= 1'b0;
    end else begin
      r_data_out_ready <= 1'b0;
      r_frame_start    <= w_frame_begin;
      r_frame_end      <= w_frame_close;
      r_frame_abort    <= w_frame_close & (r_bit_cnt != '0);

      if (w_frame_begin) begin
        r_byte_count  <= '0;
        r_tx_underrun <= 1'b0;
        r_bit_cnt     <= '0;
      end

      if (w_frame_close) begin
        r_bit_cnt <= '0;
      end

      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
        if (r_bit_cnt == '1) begin
          r_data_out       <= {r_rx_shift[6:0], w_mosi_s};
          r_data_out_ready <= 1'b1;
          if (r_byte_count != 16'hFFFF) begin
            r_byte_count <= r_byte_count + 16'd1;
          end
        end
      end

      if (w_load) begin
        r_tx_shift <= tx_valid ? tx_data : FILL_BYTE;
        if (!tx_valid) begin
          r_tx_underrun <= 1'b1;
        end
      end else if (w_shift) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  assign spi_miso_oe    = (r_state == ST_FRAME);
  assign cs_n_out       = ~spi_miso_oe;
  assign spi_miso       = spi_miso_oe ? r_tx_shift[7] : 1'b1;
  assign tx_ready       = w_load & reset_n;
  assign data_out       = r_data_out;
  assign data_out_ready = r_data_out_ready;
  assign frame_start    = r_frame_start;
  assign frame_end      = r_frame_end;
  assign frame_abort    = r_frame_abort;
  assign byte_count     = r_byte_count;
  assign tx_underrun    = r_tx_underrun;

endmodule

// File: tb/tb_spi_byte_slave.sv
// tb/tb_spi_byte_slave.sv - scoreboard bench for spi_byte_slave in modes 0 and 3
module tb_spi_byte_slave;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       sclk0, cs0_n, sclk3, cs3_n;

  logic        miso0, oe0, csout0, rdy0, txr0, fs0, fe0, fa0, und0;
  logic [7:0]  dout0;
  logic [15:0] bc0;
  logic        miso3, oe3, csout3, rdy3, txr3, fs3, fe3, fa3, und3;
  logic [7:0]  dout3;
  logic [15:0] bc3;

  always #5 clk_sys = ~clk_sys;

  spi_byte_slave #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .FILL_BYTE(8'hFF)) u_dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .spi_sclk(sclk0), .spi_mosi(mosi), .spi_cs_n(cs0_n),
    .spi_miso(miso0), .spi_miso_oe(oe0), .cs_n_out(csout0),
    .data_out(dout0), .data_out_ready(rdy0),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr0),
    .frame_start(fs0), .frame_end(fe0), .frame_abort(fa0),
    .byte_count(bc0), .tx_underrun(und0)
  );

  spi_byte_slave #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2), .FILL_BYTE(8'hFF)) u_dut3 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .spi_sclk(sclk3), .spi_mosi(mosi), .spi_cs_n(cs3_n),
    .spi_miso(miso3), .spi_miso_oe(oe3), .cs_n_out(csout3),
    .data_out(dout3), .data_out_ready(rdy3),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr3),
    .frame_start(fs3), .frame_end(fe3), .frame_abort(fa3),
    .byte_count(bc3), .tx_underrun(und3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q3[$];
  int fs_cnt0 = 0, fe_cnt0 = 0, fa_cnt0 = 0;
  int half_cyc = 6;

  // Scoreboard: every strobe must match the oldest byte sent; a strobe with
  // nothing pending is compared against an impossible 9-bit value
  always @(negedge clk_sys) begin
    logic [31:0] want;
    if (rdy0) begin
      want = (exp_q0.size() > 0) ? {24'b0, exp_q0.pop_front()} : 32'h100;
      check("dout0", {24'b0, dout0}, want);
    end
    if (rdy3) begin
      want = (exp_q3.size() > 0) ? {24'b0, exp_q3.pop_front()} : 32'h100;
      check("dout3", {24'b0, dout3}, want);
    end
    if (fs0) fs_cnt0++;
    if (fe0) fe_cnt0++;
    if (fa0) begin
      fa_cnt0++;
      check("abort_with_end0", {31'b0, fe0}, 32'd1);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Mode 0 master: drive MOSI while SCLK is low, read MISO just before the rise
  task automatic xfer0(input logic [7:0] b, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      wait_clk(half_cyc);
      mi = {mi[6:0], miso0};
      sclk0 = 1'b1;
      wait_clk(half_cyc);
      sclk0 = 1'b0;
    end
  endtask

  // Mode 3 master: falling edge launches, rising edge samples
  task automatic xfer3(input logic [7:0] b, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sclk3 = 1'b0;
      mosi  = b[i];
      wait_clk(half_cyc);
      mi = {mi[6:0], miso3};
      sclk3 = 1'b1;
      wait_clk(half_cyc);
    end
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] t1_bytes [5];
    bit found;
    t1_bytes = '{8'h0A, 8'h00, 8'h00, 8'h01, 8'h00};

    reset_n = 1'b0; mosi = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    sclk0 = 1'b0; cs0_n = 1'b1; sclk3 = 1'b1; cs3_n = 1'b1;
    wait_clk(4);
    check("rst_flags0", {23'b0, miso0, oe0, csout0, rdy0, txr0, fs0, fe0, fa0, und0}, 32'b1_0_1_000000);
    check("rst_dout0", {24'b0, dout0}, 32'h0);
    check("rst_bc0", {16'b0, bc0}, 32'h0);
    check("rst_flags3", {23'b0, miso3, oe3, csout3, rdy3, txr3, fs3, fe3, fa3, und3}, 32'b1_0_1_000000);
    reset_n = 1'b1;
    wait_clk(6);

    // 1: five bytes in one mode-0 frame
    fs_cnt0 = 0; fe_cnt0 = 0; fa_cnt0 = 0;
    cs0_n = 1'b0;
    wait_clk(half_cyc);
    for (int k = 0; k < 5; k++) begin
      exp_q0.push_back(t1_bytes[k]);
      xfer0(t1_bytes[k], 8, mi);
    end
    wait_clk(half_cyc);
    cs0_n = 1'b1;
    wait_clk(10);
    check("t1_byte_count", {16'b0, bc0}, 32'd5);
    check("t1_frame_start", fs_cnt0, 32'd1);
    check("t1_frame_end", fe_cnt0, 32'd1);
    check("t1_frame_abort", fa_cnt0, 32'd0);
    check("t1_pending", exp_q0.size(), 32'd0);

    // 2: preloaded 0xA5 then an underrun byte
    tx_data = 8'hA5; tx_valid = 1'b1;
    cs0_n = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk_sys);
      if (txr0) found = 1'b1;
    end
    check("t2_tx_ready_start", {31'b0, found}, 32'd1);
    @(posedge clk_sys); #1;
    tx_valid = 1'b0;
    wait_clk(half_cyc);
    check("t2_underrun_clr", {31'b0, und0}, 32'd0);
    check("t2_oe", {31'b0, oe0}, 32'd1);
    exp_q0.push_back(8'h11);
    xfer0(8'h11, 8, mi);
    check("t2_miso_b0", {24'b0, mi}, 32'hA5);
    wait_clk(4);
    check("t2_underrun_set", {31'b0, und0}, 32'd1);
    exp_q0.push_back(8'h22);
    xfer0(8'h22, 8, mi);
    check("t2_miso_b1", {24'b0, mi}, 32'hFF);
    wait_clk(half_cyc);
    cs0_n = 1'b1;
    wait_clk(10);
    check("t2_miso_idle", {31'b0, miso0}, 32'd1);

    // 3: partial byte aborted, then a clean 0x3C
    tx_data = 8'h00; tx_valid = 1'b1;
    fe_cnt0 = 0; fa_cnt0 = 0;
    cs0_n = 1'b0;
    wait_clk(half_cyc);
    check("t3_underrun_clr", {31'b0, und0}, 32'd0);
    xfer0(8'hE0, 3, mi);
    wait_clk(half_cyc);
    cs0_n = 1'b1;
    wait_clk(10);
    check("t3_abort", fa_cnt0, 32'd1);
    check("t3_end", fe_cnt0, 32'd1);
    cs0_n = 1'b0;
    wait_clk(half_cyc);
    exp_q0.push_back(8'h3C);
    xfer0(8'h3C, 8, mi);
    wait_clk(half_cyc);
    cs0_n = 1'b1;
    wait_clk(10);
    check("t3_dout", {24'b0, dout0}, 32'h3C);

    // 4: reset mid-byte with cs_n held low ignores the rest of that frame
    cs0_n = 1'b0;
    wait_clk(half_cyc);
    xfer0(8'hFF, 4, mi);
    reset_n = 1'b0;
    wait_clk(2);
    reset_n = 1'b1;
    xfer0(8'hFF, 4, mi);
    xfer0(8'h55, 8, mi);
    check("t4_oe", {31'b0, oe0}, 32'd0);
    check("t4_cs_out", {31'b0, csout0}, 32'd1);
    wait_clk(half_cyc);
    cs0_n = 1'b1;
    wait_clk(6);
    cs0_n = 1'b0;
    wait_clk(half_cyc);
    check("t4_oe_rearmed", {31'b0, oe0}, 32'd1);
    exp_q0.push_back(8'h81);
    xfer0(8'h81, 8, mi);
    wait_clk(half_cyc);
    cs0_n = 1'b1;
    wait_clk(10);
    check("t4_dout", {24'b0, dout0}, 32'h81);

    // 5: mode 3 instance, 0x5A in, 0xC3 out
    tx_data = 8'hC3; tx_valid = 1'b1;
    cs3_n = 1'b0;
    wait_clk(half_cyc);
    exp_q3.push_back(8'h5A);
    xfer3(8'h5A, mi);
    check("t5_miso", {24'b0, mi}, 32'hC3);
    cs3_n = 1'b1;
    wait_clk(10);
    check("t5_dout", {24'b0, dout3}, 32'h5A);
    check("t5_byte_count", {16'b0, bc3}, 32'd1);

    // 6: minimum SCLK phase, 16 back-to-back bytes
    half_cyc = 3;
    tx_valid = 1'b0;
    cs0_n = 1'b0;
    wait_clk(half_cyc);
    for (int k = 0; k < 16; k++) begin
      exp_q0.push_back(8'(k));
      xfer0(8'(k), 8, mi);
    end
    wait_clk(half_cyc);
    cs0_n = 1'b1;
    wait_clk(10);
    half_cyc = 6;
    check("t6_byte_count", {16'b0, bc0}, 32'd16);

    check("final_pending0", exp_q0.size(), 32'd0);
    check("final_pending3", exp_q3.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
